// File: rtl/wload_seq_ctrl_pkg.sv
// Shared types for the weight-load sequencer: FSM state encoding.
package wload_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        LOAD    = 3'd2,
        COMPUTE = 3'd3,
        FIN     = 3'd4
    } wl_state_t;
endpackage

// File: rtl/wload_seq_ctrl_tc_counter.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count flag
// that is high while the next increment would reach the runtime limit.
module wl_tc_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);
    logic [W-1:0] r_count;
    logic [W:0]   w_next;

    assign w_next = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
    assign o_tc   = (w_next == {1'b0, i_limit});

    // Count register: clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next[W-1:0];
        end else begin
            r_count <= r_count;
        end
    end
endmodule

// File: rtl/wload_seq_ctrl.sv
// Weight-load sequencer: clears the column chain, shifts ROWS weights per tile,
// holds them for a compute window, repeats for cfg_tiles tiles, then pulses done.
module wload_seq_ctrl
    import wload_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ROWS   = 8,
    parameter int CWIDTH = 8,
    parameter int TWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TWIDTH-1:0] cfg_tiles,
    input  logic [CWIDTH-1:0] cfg_cycles,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    output logic              o_shift_en,
    output logic              o_clr,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_comp_en,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(ROWS + 1);
    localparam logic [BW-1:0] ROWS_L = BW'(ROWS);

    wl_state_t         r_state;
    wl_state_t         w_next_state;
    logic              r_aborting;
    logic [TWIDTH-1:0] r_tiles;
    logic [CWIDTH-1:0] r_cycles;
    logic [CWIDTH:0]   w_cyc_limit;
    logic              w_abort_act, w_ready, w_hs, w_comp;
    logic              w_beat_tc, w_cyc_tc, w_tile_tc;

    assign w_abort_act = abort && (r_state != IDLE);
    assign w_hs        = w_ready && s_valid;
    assign w_comp      = (r_state == COMPUTE);
    // A programmed window of zero means the full 2**CWIDTH cycles.
    assign w_cyc_limit = (r_cycles == '0) ? {1'b1, {CWIDTH{1'b0}}} : {1'b0, r_cycles};

    wl_tc_counter #(.W(BW)) u_beat_cnt (
        .clk(clk), .rst_n(rst_n),
        .i_clr(w_abort_act || (w_hs && w_beat_tc)), .i_en(w_hs),
        .i_limit(ROWS_L), .o_tc(w_beat_tc)
    );

    wl_tc_counter #(.W(CWIDTH + 1)) u_cyc_cnt (
        .clk(clk), .rst_n(rst_n),
        .i_clr(w_abort_act || (w_comp && w_cyc_tc)), .i_en(w_comp),
        .i_limit(w_cyc_limit), .o_tc(w_cyc_tc)
    );

    wl_tc_counter #(.W(TWIDTH)) u_tile_cnt (
        .clk(clk), .rst_n(rst_n),
        .i_clr(w_abort_act || (r_state == CLEAR)), .i_en(w_comp && w_cyc_tc),
        .i_limit(r_tiles), .o_tc(w_tile_tc)
    );

    // State register, abort marker and job configuration latched at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_aborting <= 1'b0;
            r_tiles    <= '0;
            r_cycles   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_abort_act) begin
                r_aborting <= 1'b1;
            end else if (r_state == CLEAR) begin
                r_aborting <= 1'b0;
            end else begin
                r_aborting <= r_aborting;
            end
            if ((r_state == IDLE) && start) begin
                r_tiles  <= cfg_tiles;
                r_cycles <= cfg_cycles;
            end else begin
                r_tiles  <= r_tiles;
                r_cycles <= r_cycles;
            end
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        w_next_state = r_state;
        if (w_abort_act) begin
            w_next_state = CLEAR;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_next_state = (cfg_tiles != '0) ? CLEAR : FIN;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                CLEAR:   w_next_state = r_aborting ? IDLE : LOAD;
                LOAD: begin
                    if (w_hs && w_beat_tc) begin
                        w_next_state = COMPUTE;
                    end else begin
                        w_next_state = LOAD;
                    end
                end
                COMPUTE: begin
                    if (w_cyc_tc) begin
                        w_next_state = w_tile_tc ? FIN : LOAD;
                    end else begin
                        w_next_state = COMPUTE;
                    end
                end
                FIN:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Output decode from state plus the live handshake.
    always_comb begin
        w_ready   = 1'b0;
        o_clr     = 1'b0;
        o_comp_en = 1'b0;
        done      = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            CLEAR:   o_clr     = 1'b1;
            LOAD:    w_ready   = !abort;
            COMPUTE: o_comp_en = 1'b1;
            FIN:     done      = !abort;
            default: w_ready   = 1'b0;
        endcase
    end

    assign s_ready    = w_ready;
    assign o_shift_en = w_hs;
    assign o_data     = s_data;
endmodule

// File: tb/tb_wload_seq_ctrl.sv
// Directed bench for wload_seq_ctrl with a phase/remaining-count reference model.
module tb_wload_seq_ctrl;
    localparam int WIDTH = 16, ROWS = 8, CWIDTH = 4, TWIDTH = 16;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [TWIDTH-1:0] cfg_tiles = '0;
    logic [CWIDTH-1:0] cfg_cycles = '0;
    logic [WIDTH-1:0]  s_data = '0;
    logic s_ready, o_shift_en, o_clr, o_comp_en, busy, done;
    logic [WIDTH-1:0] o_data;

    wload_seq_ctrl #(.WIDTH(WIDTH), .ROWS(ROWS), .CWIDTH(CWIDTH), .TWIDTH(TWIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_tiles(cfg_tiles), .cfg_cycles(cfg_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .o_shift_en(o_shift_en), .o_clr(o_clr), .o_data(o_data),
        .o_comp_en(o_comp_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, sv_mode = 0;
    int t_shift, t_clr, t_comp, t_done, t_busy, t_bad;
    // model: phase 0 idle, 1 clear, 2 load, 3 compute, 4 fin
    int m_phase = 0, m_ab = 0, m_beats_left = 0, m_cyc_left = 0, m_tiles_left = 0, m_win = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, tallies, then model advance.
    always @(negedge clk) begin
        logic e_ready;
        if (!rst_n) begin
            m_phase = 0;
            m_ab    = 0;
        end
        e_ready = (m_phase == 2) && !abort;
        chk("s_ready", s_ready, e_ready);
        chk("shift_en", o_shift_en, e_ready && s_valid);
        chk("clr", o_clr, m_phase == 1);
        chk("comp_en", o_comp_en, m_phase == 3);
        chk("busy", busy, m_phase != 0);
        chk("done", done, (m_phase == 4) && !abort);
        chk("data", o_data, s_data);
        t_shift += o_shift_en;
        t_clr   += o_clr;
        t_comp  += o_comp_en;
        t_done  += done;
        t_busy  += busy;
        t_bad   += (o_shift_en && !s_valid);
        if (rst_n) begin
            if (abort && m_phase != 0) begin
                m_phase = 1;
                m_ab    = 1;
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_tiles_left = cfg_tiles;
                        m_win = (cfg_cycles == 0) ? (1 << CWIDTH) : int'(cfg_cycles);
                        m_ab = 0;
                        m_phase = (cfg_tiles == 0) ? 4 : 1;
                    end
                    1: if (m_ab != 0) m_phase = 0;
                       else begin m_phase = 2; m_beats_left = ROWS; end
                    2: if (s_valid) begin
                        m_beats_left--;
                        if (m_beats_left == 0) begin m_phase = 3; m_cyc_left = m_win; end
                    end
                    3: begin
                        m_cyc_left--;
                        if (m_cyc_left == 0) begin
                            m_tiles_left--;
                            m_phase = (m_tiles_left == 0) ? 4 : 2;
                            m_beats_left = ROWS;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        s_data = WIDTH'($urandom);
        if (sv_mode == 1) s_valid = cyc[0];
    endtask

    task automatic clear_t();
        t_shift = 0; t_clr = 0; t_comp = 0; t_done = 0; t_busy = 0; t_bad = 0;
    endtask

    task automatic start_job(input int tiles, input int cycles);
        cfg_tiles  = TWIDTH'(tiles);
        cfg_cycles = CWIDTH'(cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_tiles  = TWIDTH'($urandom);
        cfg_cycles = CWIDTH'($urandom);
    endtask

    task automatic wait_idle(input int max, input string name);
        int k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        chk({name, "_idle_in_time"}, k < max, 1'b1);
    endtask

    task automatic chk_job(input string name, input int sh, input int cl, input int cp, input int dn, input int bz);
        chk({name, "_shifts"}, t_shift, sh);
        chk({name, "_clrs"}, t_clr, cl);
        chk({name, "_comp_cycles"}, t_comp, cp);
        chk({name, "_dones"}, t_done, dn);
        if (bz >= 0) chk({name, "_busy_cycles"}, t_busy, bz);
    endtask

    initial begin
        clear_t();
        // Reset with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); abort = 1'($urandom); s_valid = 1'($urandom);
            cfg_tiles = TWIDTH'($urandom); cfg_cycles = CWIDTH'($urandom); s_data = WIDTH'($urandom);
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_ready", s_ready, 1'b0);
        chk("post_reset_clr", o_clr, 1'b0);

        // One tile, 4-cycle window, s_valid held high.
        s_valid = 1'b1;
        clear_t(); start_job(1, 4); wait_idle(100, "t2");
        chk_job("t2", 8, 1, 4, 1, 14);

        // Three tiles with s_valid toggling.
        sv_mode = 1;
        clear_t(); start_job(3, 4); wait_idle(300, "t3");
        chk_job("t3", 24, 1, 12, 1, -1);
        chk("t3_shift_without_valid", t_bad, 0);
        sv_mode = 0; s_valid = 1'b1;

        // Zero window means 16 cycles; zero tiles finishes immediately.
        clear_t(); start_job(1, 0); wait_idle(100, "t4a");
        chk_job("t4a", 8, 1, 16, 1, 26);
        clear_t(); start_job(0, 5); wait_idle(10, "t4b");
        chk_job("t4b", 0, 0, 0, 1, 1);

        // Abort on the 5th beat together with a start.
        clear_t(); start_job(1, 4);
        for (int k = 0; k < 50 && t_shift != 4; k++) tick();
        abort = 1'b1; start = 1'b1; cfg_tiles = 16'd1;
        tick();
        abort = 1'b0; start = 1'b0;
        wait_idle(20, "t5");
        repeat (2) tick();
        chk_job("t5", 4, 2, 0, 0, 7);

        // Async reset during compute, then a clean job.
        clear_t(); start_job(1, 4);
        for (int k = 0; k < 50 && !o_comp_en; k++) tick();
        chk("t6_reached_compute", o_comp_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_comp_drop", o_comp_en, 1'b0);
        chk("t6_busy_drop", busy, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        clear_t(); start_job(1, 4); wait_idle(100, "t6");
        chk_job("t6", 8, 1, 4, 1, 14);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
